// File: rtl/debug_trace_pkg.sv
// Shared types and sizing helpers for the debug trace buffer.
// Readout width grows by TS_W when DBG_TIMESTAMP_EN is defined.
package debug_trace_pkg;

    localparam int unsigned TS_W = 32;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArmed     = 2'd1,
        StTriggered = 2'd2,
        StDone      = 2'd3
    } trace_state_e;

    function automatic int unsigned rd_width(input int unsigned num_ch, input int unsigned ch_w);
`ifdef DBG_TIMESTAMP_EN
        return num_ch * ch_w + TS_W;
`else
        return num_ch * ch_w;
`endif
    endfunction

endpackage

// File: rtl/debug_trace_buffer_if.sv
// Readout stream of the trace buffer: valid/ready handshake with a last-word marker.
interface debug_trace_buffer_if #(
    parameter int unsigned RD_W = 256
);
    logic            rd_valid;
    logic            rd_ready;
    logic [RD_W-1:0] rd_data;
    logic            rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/debug_trace_ram.sv
// Simple dual-port trace RAM: one write port, one read port with a registered read.
// The read register holds its value while rd_en is low.
module debug_trace_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             v_clk0,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge v_clk0) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/debug_trace_buffer.sv
// Circular trace capture with masked-compare trigger, post-trigger count and oldest-first readout.
// Optional DBG_TIMESTAMP_EN stores a 32-bit cycle stamp above the samples in every entry.
module debug_trace_buffer
    import debug_trace_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 64,
    parameter int unsigned DEPTH   = 1024,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned TCW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned SW     = NUM_CH * CH_W,
    localparam int unsigned RD_W   = rd_width(NUM_CH, CH_W)
) (
    input  logic                 v_clk0,
    input  logic                 v_rst0,
    input  logic [SW-1:0]        v_debug,
    input  logic                 v_debug_vld,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [TCW-1:0]       trig_ch,
    input  logic [CH_W-1:0]      trig_mask,
    input  logic [CH_W-1:0]      trig_value,
    input  logic [AW-1:0]        post_count,
    debug_trace_buffer_if.master rd,
    output logic [1:0]           state,
    output logic [AW:0]          cap_len
);

    logic [SW-1:0]   s_data;
    logic            s_vld;
    trace_state_e    state_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, post_left_q;
    logic [AW:0]     fill_q, rd_left_q, cap_len_q;
    logic            ram_vld_q, ram_last_q;
    logic            out_vld_q, out_last_q;
    logic [RD_W-1:0] out_data_q;

    logic [CH_W-1:0] s_ch;
    logic            hit, we, re, out_free, move, ram_free, fire_last;
    logic [AW-1:0]   wr_inc, done_ptr;
    logic [AW:0]     fill_inc;
    logic [RD_W-1:0] ram_wdata, ram_rdata;

    always_ff @(posedge v_clk0 or negedge v_rst0) begin
        if (!v_rst0) begin
            s_data <= '0;
            s_vld  <= 1'b0;
        end else begin
            s_data <= v_debug;
            s_vld  <= v_debug_vld;
        end
    end

`ifdef DBG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge v_clk0 or negedge v_rst0) begin
        if (!v_rst0) ts_q <= '0;
        else         ts_q <= ts_q + 1'b1;
    end

    assign ram_wdata = {ts_q, s_data};
`else
    assign ram_wdata = s_data;
`endif

    always_comb begin
        s_ch = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (TCW'(k) == trig_ch) s_ch = s_data[k*CH_W +: CH_W];
        end
    end

    // The RAM read register doubles as the prefetch slot behind the output register.
    always_comb begin
        hit       = s_vld && (((s_ch ^ trig_value) & trig_mask) == '0);
        we        = s_vld && (state_q == StArmed || state_q == StTriggered) && !abort;
        out_free  = !out_vld_q || rd.rd_ready;
        move      = ram_vld_q && out_free;
        ram_free  = !ram_vld_q || move;
        re        = (state_q == StDone) && (rd_left_q != '0) && ram_free && !abort;
        fire_last = out_vld_q && rd.rd_ready && out_last_q;
        wr_inc    = wr_ptr_q + 1'b1;
        fill_inc  = (fill_q == (AW+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;
        done_ptr  = wr_inc - fill_inc[AW-1:0];
    end

    always_ff @(posedge v_clk0 or negedge v_rst0) begin
        if (!v_rst0) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_left_q <= '0;
            fill_q      <= '0;
            rd_left_q   <= '0;
            cap_len_q   <= '0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (abort) begin
            state_q    <= StIdle;
            rd_left_q  <= '0;
            ram_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_q  <= StArmed;
                        wr_ptr_q <= '0;
                        fill_q   <= '0;
                    end
                end
                StArmed, StTriggered: begin
                    if (we) begin
                        wr_ptr_q <= wr_inc;
                        fill_q   <= fill_inc;
                        if (state_q == StTriggered) post_left_q <= post_left_q - 1'b1;
                        else if (hit) post_left_q <= post_count;
                        if ((state_q == StArmed && hit && post_count == '0) ||
                            (state_q == StTriggered && post_left_q == AW'(1))) begin
                            state_q   <= StDone;
                            cap_len_q <= fill_inc;
                            rd_left_q <= fill_inc;
                            rd_ptr_q  <= done_ptr;
                        end else if (state_q == StArmed && hit) begin
                            state_q <= StTriggered;
                        end
                    end
                end
                StDone: begin
                    if (re) begin
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        rd_left_q  <= rd_left_q - 1'b1;
                        ram_last_q <= (rd_left_q == (AW+1)'(1));
                    end
                    ram_vld_q <= re || (ram_vld_q && !move);
                    if (move) begin
                        out_vld_q  <= 1'b1;
                        out_data_q <= ram_rdata;
                        out_last_q <= ram_last_q;
                    end else if (rd.rd_ready) begin
                        out_vld_q  <= 1'b0;
                        out_last_q <= 1'b0;
                    end
                    if (fire_last) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    debug_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RD_W)
    ) u_ram (
        .v_clk0  (v_clk0),
        .wr_en   (we),
        .wr_addr (wr_ptr_q),
        .wr_data (ram_wdata),
        .rd_en   (re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    assign rd.rd_valid = out_vld_q;
    assign rd.rd_data  = out_data_q;
    assign rd.rd_last  = out_last_q;
    assign state       = state_q;
    assign cap_len     = cap_len_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer: table of capture scenarios plus abort/reset sequences.
module tb_debug_trace_buffer;
    import debug_trace_pkg::*;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 8;
    localparam int DEPTH  = 16;
    localparam int RD_W   = rd_width(NUM_CH, CH_W);

    logic        v_clk0 = 1'b0;
    logic        v_rst0 = 1'b0;
    logic [15:0] v_debug = '0;
    logic        v_debug_vld = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [0:0]  trig_ch = '0;
    logic [7:0]  trig_mask = '0;
    logic [7:0]  trig_value = '0;
    logic [3:0]  post_count = '0;
    logic [1:0]  state;
    logic [4:0]  cap_len;

    int tests = 0;
    int fails = 0;
    int c     = 0;

    always #5 v_clk0 = ~v_clk0;

    debug_trace_buffer_if #(.RD_W(RD_W)) rd_if ();

    debug_trace_buffer #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .DEPTH  (DEPTH)
    ) dut (
        .v_clk0      (v_clk0),
        .v_rst0      (v_rst0),
        .v_debug     (v_debug),
        .v_debug_vld (v_debug_vld),
        .arm         (arm),
        .abort       (abort),
        .trig_ch     (trig_ch),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .post_count  (post_count),
        .rd          (rd_if),
        .state       (state),
        .cap_len     (cap_len)
    );

    typedef struct {
        logic [7:0] val;
        logic [7:0] mask;
        logic [3:0] post;
        int         div;
        bit         toggle;
        int         first;
        int         cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge v_clk0);
        #1;
    endtask

    // Channel 0 carries the cycle counter, channel 1 its XOR with 0xA5.
    task automatic stream_until(input logic [1:0] st, input int div);
        int g = 0;
        while (state != st && g < 200) begin
            v_debug     = {8'(c) ^ 8'hA5, 8'(c)};
            v_debug_vld = (c % div == 0);
            step();
            c++;
            g++;
        end
        v_debug_vld = 1'b0;
    endtask

    task automatic arm_with(input logic [7:0] val, input logic [7:0] mask, input logic [3:0] post);
        v_debug_vld = 1'b0;
        trig_value  = val;
        trig_mask   = mask;
        post_count  = post;
        arm         = 1'b1;
        step();
        arm = 1'b0;
        c   = 0;
    endtask

    task automatic run_scn(input vec_t v, input string tag);
        int n = 0;
        int g = 0;
        logic hold = 1'b0;
        logic [RD_W-1:0] hd = '0;
        logic [7:0] e0;
`ifdef DBG_TIMESTAMP_EN
        logic [31:0] pts = '0;
`endif
        arm_with(v.val, v.mask, v.post);
        chk({tag, "_armed"}, 64'(state), 64'(1));
        stream_until(2'd3, v.div);
        chk({tag, "_done"}, 64'(state), 64'(3));
        chk({tag, "_cap_len"}, 64'(cap_len), 64'(v.cnt));
        while (n < v.cnt && g < 300) begin
            if (hold) begin
                chk({tag, "_stall_hold"}, 64'({rd_if.rd_valid, rd_if.rd_data}), 64'({1'b1, hd}));
                hold = 1'b0;
            end
            rd_if.rd_ready = v.toggle ? (g % 2 == 0) : 1'b1;
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                e0 = 8'(v.first + n * v.div);
                chk({tag, "_data"}, 64'(rd_if.rd_data[15:0]), 64'({e0 ^ 8'hA5, e0}));
                chk({tag, "_last"}, 64'(rd_if.rd_last), 64'(n == v.cnt - 1));
`ifdef DBG_TIMESTAMP_EN
                if (n > 0) chk({tag, "_ts_delta"}, 64'(rd_if.rd_data[RD_W-1 -: 32] - pts), 64'(v.div));
                pts = rd_if.rd_data[RD_W-1 -: 32];
`endif
                n++;
            end else if (rd_if.rd_valid) begin
                hold = 1'b1;
                hd   = rd_if.rd_data;
            end
            step();
            g++;
        end
        rd_if.rd_ready = 1'b0;
        chk({tag, "_words"}, 64'(n), 64'(v.cnt));
        chk({tag, "_idle"}, 64'(state), 64'(0));
        chk({tag, "_valid_off"}, 64'(rd_if.rd_valid), 64'(0));
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'hFF, 4'd3, 1, 1'b0, 'h00, 9};
        vecs[1] = '{8'h40, 8'hFF, 4'd3, 1, 1'b0, 'h34, 16};
        vecs[2] = '{8'h40, 8'hFF, 4'd3, 1, 1'b1, 'h34, 16};
        vecs[3] = '{8'h0A, 8'hFF, 4'd3, 2, 1'b0, 'h00, 9};
        vecs[4] = '{8'h03, 8'hFF, 4'd0, 1, 1'b0, 'h00, 4};
        vecs[5] = '{8'h77, 8'h00, 4'd2, 1, 1'b0, 'h00, 3};
        vecs[6] = '{8'h40, 8'hFF, 4'd3, 2, 1'b1, 'h28, 16};

        rd_if.rd_ready = 1'b0;
        step();
        step();
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_valid", 64'(rd_if.rd_valid), 64'(0));
        chk("rst_last", 64'(rd_if.rd_last), 64'(0));
        chk("rst_data", 64'(rd_if.rd_data), 64'(0));
        chk("rst_cap_len", 64'(cap_len), 64'(0));
        v_rst0 = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_scn(vecs[i], $sformatf("scn%0d", i));

        // Abort while collecting post-trigger samples, then a fresh capture.
        arm_with(8'h05, 8'hFF, 4'd10);
        stream_until(2'd2, 1);
        chk("abort_pre_state", 64'(state), 64'(2));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", 64'(state), 64'(0));
        chk("abort_valid", 64'(rd_if.rd_valid), 64'(0));
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_state", 64'(state), 64'(0));
        run_scn(vecs[0], "fresh");

        // Asynchronous reset in the middle of a readout clears every output.
        arm_with(8'h05, 8'hFF, 4'd3);
        stream_until(2'd3, 1);
        rd_if.rd_ready = 1'b1;
        step();
        step();
        step();
        chk("midrd_valid", 64'(rd_if.rd_valid), 64'(1));
        v_rst0 = 1'b0;
        #1;
        chk("midrd_rst_state", 64'(state), 64'(0));
        chk("midrd_rst_valid", 64'(rd_if.rd_valid), 64'(0));
        chk("midrd_rst_last", 64'(rd_if.rd_last), 64'(0));
        chk("midrd_rst_data", 64'(rd_if.rd_data), 64'(0));
        chk("midrd_rst_cap_len", 64'(cap_len), 64'(0));
        rd_if.rd_ready = 1'b0;
        step();
        v_rst0 = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
